// File: rtl/framebuffer_pkg.sv
// Shared types, palette constants, FSM encodings and cell addressing for the
// etch-a-sketch framebuffer.
package framebuffer_pkg;

    typedef logic [1:0]  palette_index_t;
    typedef logic [15:0] rgb565_t;

    localparam palette_index_t PAL_BLACK = 2'd0;
    localparam palette_index_t PAL_WHITE = 2'd1;
    localparam palette_index_t PAL_RED   = 2'd2;
    localparam palette_index_t PAL_BLUE  = 2'd3;

    // Same encodings as the ILI9341 colour type in the display defines.
    localparam rgb565_t COLOR_BLACK = 16'h0000;
    localparam rgb565_t COLOR_WHITE = 16'hFFFF;
    localparam rgb565_t COLOR_RED   = 16'hF800;
    localparam rgb565_t COLOR_BLUE  = 16'h001F;

    typedef enum logic [1:0] {
        R_FETCH   = 2'd0,
        R_MEM     = 2'd1,
        R_PRESENT = 2'd2
    } read_state_t;

    typedef enum logic [0:0] {
        W_CLEAR = 1'b0,
        W_IDLE  = 1'b1
    } write_state_t;

    // Row-major cell index; wide enough for any 8-bit x / 9-bit y, callers
    // narrow it to their RAM address width.
    function automatic logic [15:0] cell_addr(input logic [7:0] x, input logic [8:0] y,
                                              input int unsigned shift, input logic [15:0] cols);
        logic [15:0] row_s;
        logic [15:0] col_s;
        row_s = 16'(y >> shift);
        col_s = 16'(x >> shift);
        return 16'(row_s * cols) + col_s;
    endfunction

    function automatic rgb565_t palette_lookup(input palette_index_t idx);
        rgb565_t color_s;
        case (idx)
            PAL_BLACK: color_s = COLOR_BLACK;
            PAL_WHITE: color_s = COLOR_WHITE;
            PAL_RED:   color_s = COLOR_RED;
            PAL_BLUE:  color_s = COLOR_BLUE;
            default:   color_s = COLOR_BLACK;
        endcase
        return color_s;
    endfunction

endpackage

// File: rtl/block_ram_dp.sv
// Simple dual-port RAM: one write port, one registered read port. A read and a
// write to the same address in one cycle return the old contents.
module block_ram_dp #(
    parameter int W = 2,
    parameter int L = 1200,
    localparam int AW = (L > 1) ? $clog2(L) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_r [L];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port; sees the array before this edge's write.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem_r[raddr];
        end
    end

endmodule

// File: rtl/etch_a_sketch_framebuffer.sv
// Cell framebuffer for the etch-a-sketch: a draw/clear write side and a
// raster-order RGB565 pixel stream for the ILI9341 controller.
module etch_a_sketch_framebuffer
    import framebuffer_pkg::*;
#(
    parameter int DISPLAY_WIDTH  = 240,
    parameter int DISPLAY_HEIGHT = 320,
    parameter int CELL_SHIFT     = 3
) (
    input  logic        clk,
    input  logic        rstb,
    input  logic        ena,
    input  logic        draw_valid,
    output logic        draw_ready,
    input  logic [7:0]  draw_x,
    input  logic [8:0]  draw_y,
    input  logic [1:0]  draw_color,
    input  logic        clear_req,
    output logic        busy,
    output logic        px_valid,
    input  logic        px_ready,
    output logic [15:0] px_color,
    output logic        px_hsync,
    output logic        px_vsync
);

    localparam int COLS   = DISPLAY_WIDTH >> CELL_SHIFT;
    localparam int ROWS   = DISPLAY_HEIGHT >> CELL_SHIFT;
    localparam int CELLS  = COLS * ROWS;
    localparam int ADDR_W = $clog2(CELLS);

    localparam logic [7:0]        X_LAST    = 8'(DISPLAY_WIDTH - 1);
    localparam logic [8:0]        Y_LAST    = 9'(DISPLAY_HEIGHT - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(CELLS - 1);
    localparam logic [15:0]       COLS_W    = 16'(COLS);

    read_state_t       read_state_r, read_state_s;
    write_state_t      write_state_r, write_state_s;
    logic [7:0]        scan_x_r, scan_x_s;
    logic [8:0]        scan_y_r, scan_y_s;
    rgb565_t           px_color_r;
    logic              px_hsync_r;
    logic              px_vsync_r;
    logic [ADDR_W-1:0] clear_addr_r, clear_addr_s;
    logic              rd_en_s;
    logic [ADDR_W-1:0] rd_addr_s;
    palette_index_t    rd_data_s;
    logic              wr_en_s;
    logic [ADDR_W-1:0] wr_addr_s;
    palette_index_t    wr_data_s;
    logic              draw_in_range_s;

    assign px_valid   = ena & (read_state_r == R_PRESENT);
    assign draw_ready = ena & (write_state_r == W_IDLE) & ~clear_req;
    assign busy       = (write_state_r == W_CLEAR);
    assign px_color   = px_color_r;
    assign px_hsync   = px_hsync_r;
    assign px_vsync   = px_vsync_r;

    assign rd_en_s         = ena & (read_state_r == R_FETCH);
    assign rd_addr_s       = ADDR_W'(cell_addr(scan_x_r, scan_y_r, CELL_SHIFT, COLS_W));
    assign draw_in_range_s = (draw_x <= X_LAST) && (draw_y <= Y_LAST);

    block_ram_dp #(
        .W (2),
        .L (CELLS)
    ) u_cell_ram (
        .clk   (clk),
        .we    (wr_en_s),
        .waddr (wr_addr_s),
        .wdata (wr_data_s),
        .re    (rd_en_s),
        .raddr (rd_addr_s),
        .rdata (rd_data_s)
    );

    // Read FSM next state and scan position; the scan advances only on an accepted pixel.
    always_comb begin
        read_state_s = read_state_r;
        scan_x_s     = scan_x_r;
        scan_y_s     = scan_y_r;
        case (read_state_r)
            R_FETCH: read_state_s = R_MEM;
            R_MEM:   read_state_s = R_PRESENT;
            R_PRESENT: begin
                if (px_ready) begin
                    read_state_s = R_FETCH;
                    if (scan_x_r == X_LAST) begin
                        scan_x_s = 8'd0;
                        if (scan_y_r == Y_LAST) begin
                            scan_y_s = 9'd0;
                        end else begin
                            scan_y_s = scan_y_r + 9'd1;
                        end
                    end else begin
                        scan_x_s = scan_x_r + 8'd1;
                    end
                end else begin
                    read_state_s = R_PRESENT;
                end
            end
            default: read_state_s = R_FETCH;
        endcase
    end

    // Read FSM registers and the presented pixel, which hold until accepted.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            read_state_r <= R_FETCH;
            scan_x_r     <= 8'd0;
            scan_y_r     <= 9'd0;
            px_color_r   <= 16'h0000;
            px_hsync_r   <= 1'b0;
            px_vsync_r   <= 1'b0;
        end else if (ena) begin
            read_state_r <= read_state_s;
            scan_x_r     <= scan_x_s;
            scan_y_r     <= scan_y_s;
            if (read_state_r == R_MEM) begin
                px_color_r <= palette_lookup(rd_data_s);
                px_hsync_r <= (scan_x_r == X_LAST);
                px_vsync_r <= (scan_x_r == X_LAST) && (scan_y_r == Y_LAST);
            end
        end
    end

    // Write FSM: sweep zeros through every cell, otherwise accept draws; clear beats a draw.
    always_comb begin
        write_state_s = write_state_r;
        clear_addr_s  = clear_addr_r;
        wr_en_s       = 1'b0;
        wr_addr_s     = clear_addr_r;
        wr_data_s     = PAL_BLACK;
        case (write_state_r)
            W_CLEAR: begin
                wr_en_s = ena;
                if (clear_addr_r == ADDR_LAST) begin
                    write_state_s = W_IDLE;
                    clear_addr_s  = {ADDR_W{1'b0}};
                end else begin
                    clear_addr_s = clear_addr_r + ADDR_W'(1'b1);
                end
            end
            W_IDLE: begin
                if (clear_req) begin
                    write_state_s = W_CLEAR;
                    clear_addr_s  = {ADDR_W{1'b0}};
                end else if (draw_valid && draw_in_range_s) begin
                    wr_en_s   = ena;
                    wr_addr_s = ADDR_W'(cell_addr(draw_x, draw_y, CELL_SHIFT, COLS_W));
                    wr_data_s = draw_color;
                end else begin
                    wr_en_s = 1'b0;
                end
            end
            default: begin
                write_state_s = W_CLEAR;
                clear_addr_s  = {ADDR_W{1'b0}};
            end
        endcase
    end

    // Write FSM registers.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            write_state_r <= W_CLEAR;
            clear_addr_r  <= {ADDR_W{1'b0}};
        end else if (ena) begin
            write_state_r <= write_state_s;
            clear_addr_r  <= clear_addr_s;
        end
    end

endmodule
